// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The bypass path is compiled in only when ARB_BYPASS_EN is defined.
package arbitro_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  // One register-file write: destination index plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Owner of the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MC
  } grant_e;

  // One-hot register mask; x0 never gets a bit because it is hardwired to zero.
  function automatic logic [NUM_REGS-1:0] regMask(input logic [ADDR_W-1:0] idx,
                                                  input logic              en);
    regMask = '0;
    if (en && idx != '0) regMask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/arbitro_escritura_banco_if.sv
// Bus between the writeback/multicycle units, the decode stage and the
// arbiter that drives the banco_registros write port.
// slave  = the arbiter, master = the surrounding pipeline.
interface arbitro_escritura_banco_if #(
  parameter int DATA_W     = arbitro_pkg::DATA_W,
  parameter int ADDR_W     = arbitro_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
);

  logic                          wbValid;
  logic [ADDR_W-1:0]             wbReg;
  logic [DATA_W-1:0]             wbData;
  logic                          mcValid;
  logic                          mcReady;
  logic [ADDR_W-1:0]             mcReg;
  logic [DATA_W-1:0]             mcData;
  logic                          mcIssue;
  logic [ADDR_W-1:0]             mcIssueReg;
  logic [ADDR_W-1:0]             readReg1;
  logic [ADDR_W-1:0]             readReg2;
  logic                          stall;
  logic [ADDR_W-1:0]             writeReg;
  logic [DATA_W-1:0]             writeData;
  logic                          RegWrite;
  logic [$clog2(FIFO_DEPTH):0]   fifoCount;
  logic                          hazErr;

  modport slave (
    input  wbValid, wbReg, wbData,
    input  mcValid, mcReg, mcData,
    input  mcIssue, mcIssueReg,
    input  readReg1, readReg2,
    output mcReady, stall,
    output writeReg, writeData, RegWrite,
    output fifoCount, hazErr
  );

  modport master (
    output wbValid, wbReg, wbData,
    output mcValid, mcReg, mcData,
    output mcIssue, mcIssueReg,
    output readReg1, readReg2,
    input  mcReady, stall,
    input  writeReg, writeData, RegWrite,
    input  fifoCount, hazErr
  );

endinterface

// File: rtl/arbitro_escritura_banco_fifo_escritura.sv
// Small synchronous FIFO of pending register-file writes. DEPTH must be a
// power of two so the pointers wrap on their own.
module fifo_escritura
  import arbitro_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  wr_req_t                  pushData,
  input  logic                     pop,
  output wr_req_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_req_t           mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign doPush = push && (!full || pop);
  assign doPop  = pop && !empty;

  assign head  = mem[rdPtr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage write; only the pointers/count need reset.
  // NOTE: the data array is left unreset on purpose: an entry is only read once
  // the count says it was written, and skipping the reset keeps it a plain RAM;
  // sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arbitro_escritura_banco.sv
// Write-port arbiter and pending-write scoreboard for banco_registros.
// Writeback has fixed priority; multicycle results queue in fifo_escritura.
// Optional macro ARB_BYPASS_EN: an empty FIFO lets a multicycle result drive
// the port in the same cycle it arrives.
module arbitro_escritura_banco
  import arbitro_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                      CLK,
  input logic                      RST,
  arbitro_escritura_banco_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_req_t              fifoHead;
  wr_req_t              mcReq;
  wr_req_t              portReq;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [CNT_W-1:0]     fifoCnt;
  logic                 fifoPush;
  logic                 fifoPop;
  logic                 mcAccept;
  logic                 bypassSel;
  grant_e               grant;
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  setMask;
  logic [NUM_REGS-1:0]  clrMask;
  logic                 hazErrQ;

  assign mcReq = '{dst: bus.mcReg, data: bus.mcData};

  // Port grant: writeback first, then FIFO head, then (optionally) bypass.
  // NOTE: every signal gets a default before the if-chain so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant     = GNT_NONE;
    bypassSel = 1'b0;
    portReq   = '0;
    if (!RST) begin
      if (bus.wbValid && bus.wbReg != '0) begin
        grant   = GNT_WB;
        portReq = '{dst: bus.wbReg, data: bus.wbData};
      end else if (!fifoEmpty) begin
        grant   = GNT_MC;
        portReq = fifoHead;
      end
`ifdef ARB_BYPASS_EN
      else if (bus.mcValid && bus.mcReg != '0) begin
        grant     = GNT_MC;
        bypassSel = 1'b1;
        portReq   = mcReq;
      end
`endif
    end
  end

  // A FIFO grant pops the head; a bypass grant never touched the FIFO.
  assign fifoPop  = (grant == GNT_MC) && !bypassSel;

  // Ready while there is room, or when the head leaves this same cycle.
  assign bus.mcReady = !RST && (!fifoFull || fifoPop);
  assign mcAccept    = bus.mcValid && bus.mcReady;

  // x0 results complete the handshake but are dropped; bypassed ones are already written.
  assign fifoPush = mcAccept && (bus.mcReg != '0) && !bypassSel;

  fifo_escritura #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (fifoPush),
    .pushData (mcReq),
    .pop      (fifoPop),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCnt)
  );

  assign bus.RegWrite  = (grant != GNT_NONE);
  assign bus.writeReg  = portReq.dst;
  assign bus.writeData = portReq.data;
  assign bus.fifoCount = fifoCnt;

  // Issue marks a destination pending; the multicycle write that lands clears it.
  assign setMask = regMask(bus.mcIssueReg, bus.mcIssue);
  assign clrMask = regMask(portReq.dst, grant == GNT_MC);

  // Scoreboard update; applying the set after the clear makes a same-cycle set win.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pending <= '0;
    else     pending <= (pending & ~clrMask) | setMask;
  end

  // The current cycle's issue is not visible until the next cycle.
  assign bus.stall = pending[bus.readReg1] | pending[bus.readReg2];

  // Sticky flag: a writeback overtook an outstanding multicycle write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                       hazErrQ <= 1'b0;
    else if (grant == GNT_WB && pending[bus.wbReg]) hazErrQ <= 1'b1;
  end

  assign bus.hazErr = hazErrQ;

endmodule
